a2d_scan: RTL and testbench

A2D_SCAN -- requirements
Module: a2d_scan

---
 rtl/a2d_scan.sv | 119 +++++++++++
 tb/tb_a2d_scan.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_scan.sv
// a2d_scan: round-robin A2D channel scanner. Starts one conversion per channel,
// stores each result in a per-channel bank and flags conversions that never complete.
module a2d_scan #(
    parameter int NUM_CHNNL   = 8,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        err_clr,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    input  logic [2:0]  rd_chnnl,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic [11:0] rd_data,
    output logic        scan_done,
    output logic        busy,
    output logic        err,
    output logic [1:0]  state_dbg
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [2:0]       CH_LAST  = 3'(NUM_CHNNL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [SET_W-1:0] set_cnt;
    logic [11:0]      bank [0:7];
    logic             cmplt_hit;
    logic             tmo_hit;
    logic             wait_exit;
    logic             settle_end;

    assign state_dbg = state;

    // Handshake: strt_cnv is a single-cycle request; the A2D side answers with a
    // single-cycle cnv_cmplt carrying res. Only a cnv_cmplt seen in WAIT is accepted,
    // and a completion on the last timeout cycle still counts as a completion.
    always_comb begin
        cmplt_hit  = (state == WAIT) && cnv_cmplt;
        tmo_hit    = (state == WAIT) && !cnv_cmplt && (tmo_cnt == TMO_LAST);
        wait_exit  = cmplt_hit || tmo_hit;
        settle_end = (state == SETTLE) && (set_cnt == SET_LAST);
    end

    always_comb begin
        state_nxt = state;
        strt_cnv  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (en) state_nxt = START;
            end
            START: begin
                strt_cnv  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_exit) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (settle_end) state_nxt = en ? START : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Counters run only inside their own state and sit at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            set_cnt   <= '0;
            chnnl     <= 3'd0;
            scan_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            tmo_cnt   <= (state == WAIT && !wait_exit) ? tmo_cnt + TMO_W'(1) : '0;
            set_cnt   <= (state == SETTLE && !settle_end) ? set_cnt + SET_W'(1) : '0;
            scan_done <= wait_exit && (chnnl == CH_LAST);
            if (wait_exit)
                chnnl <= (chnnl == CH_LAST) ? 3'd0 : chnnl + 3'd1;
            else if (settle_end && !en)
                chnnl <= 3'd0;
            if (tmo_hit)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

    // rd_data samples the bank before this edge's write lands (old value on collision).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) bank[i] <= 12'd0;
            rd_data <= 12'd0;
        end else begin
            if (cmplt_hit) bank[chnnl] <= res;
            rd_data <= bank[rd_chnnl];
        end
    end

endmodule

// File: tb/tb_a2d_scan.sv
// tb_a2d_scan: directed bench for a2d_scan with an A2D responder, a timestamp-based
// reference model checked every cycle, and literal expectations for each scenario.
module tb_a2d_scan;

    localparam int NUM_CHNNL   = 8;
    localparam int SETTLE_CYC  = 16;
    localparam int TIMEOUT_CYC = 4096;
    localparam int CNV_LAT     = 40;
    localparam int PERIOD      = 1 + CNV_LAT + SETTLE_CYC;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        en        = 1'b0;
    logic        err_clr   = 1'b0;
    logic        cnv_cmplt = 1'b0;
    logic [11:0] res       = 12'd0;
    logic [2:0]  rd_chnnl  = 3'd0;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [11:0] rd_data;
    logic        scan_done;
    logic        busy;
    logic        err;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    a2d_scan #(
        .NUM_CHNNL  (NUM_CHNNL),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .err_clr  (err_clr),
        .cnv_cmplt(cnv_cmplt),
        .res      (res),
        .rd_chnnl (rd_chnnl),
        .strt_cnv (strt_cnv),
        .chnnl    (chnnl),
        .rd_data  (rd_data),
        .scan_done(scan_done),
        .busy     (busy),
        .err      (err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: wait expired, got no event expected one at %0t", name, $time);
    endtask

    // A2D responder: answers each start with res_tab[ch] CNV_LAT cycles later.
    logic [11:0] res_tab [8];
    int          skip_ch = 8;
    bit          stray   = 1'b0;
    bit          pend    = 1'b0;
    int          a_cnt   = 0;
    int          a_ch    = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend      = 1'b0;
            cnv_cmplt = 1'b0;
        end else begin
            cnv_cmplt = 1'b0;
            if (strt_cnv) begin
                pend  = 1'b1;
                a_cnt = 0;
                a_ch  = int'(chnnl);
            end else if (pend) begin
                a_cnt++;
                if (a_cnt == CNV_LAT) begin
                    pend = 1'b0;
                    if (a_ch != skip_ch) begin
                        cnv_cmplt = 1'b1;
                        res       = res_tab[a_ch];
                    end
                end
            end
            if (stray) begin
                cnv_cmplt = 1'b1;
                res       = 12'hFFF;
            end
        end
    end

    // Event log of start pulses and frame ends.
    logic [2:0] start_q [$];
    int         start_t [$];
    int         done_cnt = 0;
    int         neg_cnt  = 0;

    always @(negedge clk) begin
        neg_cnt++;
        if (rst_n && strt_cnv) begin
            start_q.push_back(chnnl);
            start_t.push_back(neg_cnt);
        end
        if (rst_n && scan_done) done_cnt++;
    end

    // Reference model: tracks the cycle a conversion started and the cycle its wait
    // ended, and derives every output from those timestamps.
    int          m_cyc   = 0;
    bit          m_busy  = 1'b0;
    int          m_start = -1;
    int          m_end   = -1;
    int          m_ch    = 0;
    bit          m_err   = 1'b0;
    bit          m_done  = 1'b0;
    logic [11:0] m_rd    = 12'd0;
    logic [11:0] m_bank [8];

    always @(posedge clk) begin
        int c;
        bit tmo;
        c      = m_cyc;
        tmo    = 1'b0;
        m_done = 1'b0;
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_start = -1;
            m_end   = -1;
            m_ch    = 0;
            m_err   = 1'b0;
            m_rd    = 12'd0;
            for (int i = 0; i < 8; i++) m_bank[i] = 12'd0;
        end else begin
            m_rd = m_bank[rd_chnnl];
            if (!m_busy) begin
                if (en) begin
                    m_busy  = 1'b1;
                    m_start = c + 1;
                    m_end   = -1;
                end
            end else if (m_end < 0) begin
                if (c > m_start && cnv_cmplt) begin
                    m_bank[m_ch] = res;
                    m_end        = c + 1;
                end else if (c - m_start == TIMEOUT_CYC) begin
                    tmo   = 1'b1;
                    m_end = c + 1;
                end
                if (m_end == c + 1) begin
                    m_done = (m_ch == NUM_CHNNL - 1);
                    m_ch   = (m_ch + 1) % NUM_CHNNL;
                end
            end else if (c == m_end + SETTLE_CYC - 1) begin
                if (en) begin
                    m_start = c + 1;
                    m_end   = -1;
                end else begin
                    m_busy = 1'b0;
                    m_ch   = 0;
                end
            end
            if (tmo)          m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
        m_cyc = c + 1;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            if (!rst_n) begin
                chk("rst_strt_cnv", strt_cnv, 0);
                chk("rst_chnnl", chnnl, 0);
                chk("rst_scan_done", scan_done, 0);
                chk("rst_busy", busy, 0);
                chk("rst_err", err, 0);
                chk("rst_rd_data", rd_data, 0);
            end else begin
                chk("strt_cnv", strt_cnv, m_busy && (m_start == m_cyc));
                chk("chnnl", chnnl, m_ch);
                chk("scan_done", scan_done, m_done);
                chk("busy", busy, m_busy);
                chk("err", err, m_err);
                chk("rd_data", rd_data, m_rd);
            end
        end
    end

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (scan_done) return;
        end
        tmo_fail("wait_scan_done");
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        tmo_fail("wait_idle");
    endtask

    task automatic wait_start_ch(input logic [2:0] ch, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (strt_cnv && chnnl == ch) return;
        end
        tmo_fail("wait_start");
    endtask

    task automatic read_bank(input logic [2:0] k, input logic [11:0] exp, input string name);
        rd_chnnl = k;
        @(negedge clk);
        chk(name, rd_data, exp);
    endtask

    task automatic set_res_base(input logic [11:0] base);
        for (int k = 0; k < 8; k++) res_tab[k] = base + 12'(k);
    endtask

    initial begin
        #1_000_000;
        n_checks++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        int q0;
        int d0;
        int n;

        set_res_base(12'h100);

        // Reset values
        @(negedge clk);
        chk("reset_strt_cnv", strt_cnv, 0);
        chk("reset_chnnl", chnnl, 0);
        chk("reset_scan_done", scan_done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        chk("reset_rd_data", rd_data, 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        repeat (3) @(negedge clk);

        // Full frame: channels 0..7, one scan_done, bank holds 0x100+k
        q0 = start_q.size();
        d0 = done_cnt;
        en = 1'b1;
        wait_done(2000);
        en = 1'b0;
        wait_idle(200);
        chk("frame_start_count", start_q.size() - q0, 8);
        for (int k = 0; k < 8; k++) chk("frame_start_order", start_q[q0 + k], k);
        chk("frame_done_count", done_cnt - d0, 1);
        chk("start_period", start_t[q0 + 1] - start_t[q0], PERIOD);
        for (int k = 0; k < 8; k++) read_bank(3'(k), 12'h100 + 12'(k), "bank_frame1");

        // Channel 3 never completes: timeout, bank[3] kept, scan goes on to ch4
        set_res_base(12'h200);
        skip_ch = 3;
        q0 = start_q.size();
        en = 1'b1;
        wait_done(8000);
        en = 1'b0;
        wait_idle(200);
        skip_ch = 8;
        chk("timeout_err", err, 1);
        chk("timeout_start_count", start_q.size() - q0, 8);
        chk("timeout_next_ch", start_q[q0 + 4], 4);
        read_bank(3'd3, 12'h103, "timeout_bank3_kept");
        read_bank(3'd4, 12'h204, "timeout_bank4");

        // err_clr alone clears; err_clr together with a timeout leaves err set
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr_alone", err, 0);
        skip_ch = 0;
        en = 1'b1;
        wait_start_ch(3'd0, 50);
        en = 1'b0;
        repeat (TIMEOUT_CYC) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_set_wins", err, 1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr_later", err, 0);
        wait_idle(100);
        skip_ch = 8;
        read_bank(3'd0, 12'h200, "timeout_bank0_kept");

        // en dropped 5 clocks after START on ch2: conversion finishes, then IDLE
        set_res_base(12'h300);
        en = 1'b1;
        wait_start_ch(3'd2, 300);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stop_latency", n, PERIOD);
        chk("stop_chnnl", chnnl, 0);
        chk("stop_busy", busy, 0);
        read_bank(3'd2, 12'h302, "stop_bank2");

        // Read/write collision on entry 5
        res_tab[5] = 12'hABC;
        rd_chnnl   = 3'd5;
        en = 1'b1;
        wait_start_ch(3'd5, 1000);
        en = 1'b0;
        repeat (CNV_LAT) @(negedge clk);
        @(negedge clk);
        chk("collide_old", rd_data, 12'h205);
        @(negedge clk);
        chk("collide_new", rd_data, 12'hABC);
        wait_idle(100);

        // Reset asserted during WAIT on ch6
        en = 1'b1;
        wait_start_ch(3'd6, 1000);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("midrst_strt_cnv", strt_cnv, 0);
        chk("midrst_chnnl", chnnl, 0);
        chk("midrst_scan_done", scan_done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        chk("midrst_rd_data", rd_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) read_bank(3'(k), 12'h000, "midrst_bank_clear");

        // cnv_cmplt while idle must not write the bank
        rd_chnnl = 3'd0;
        @(posedge clk);
        stray = 1'b1;
        @(posedge clk);
        stray = 1'b0;
        @(negedge clk);
        @(negedge clk);
        read_bank(3'd0, 12'h000, "stray_cmplt_ignored");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
